// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcodes, execute FSM encoding, datapath sizes and decode helpers.
// Opcode C decodes as legal only when CPU_EXEC_MUL_EN is defined.
package cpu_pkg;

    localparam int CPU_DATA_W = 16;
    localparam int CPU_ADDR_W = 4;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_OR   = 4'h4;
    localparam logic [3:0] OP_XOR  = 4'h5;
    localparam logic [3:0] OP_NOT  = 4'h6;
    localparam logic [3:0] OP_SHL  = 4'h7;
    localparam logic [3:0] OP_SHR  = 4'h8;
    localparam logic [3:0] OP_LDI  = 4'h9;
    localparam logic [3:0] OP_ADDI = 4'hA;
    localparam logic [3:0] OP_MOV  = 4'hB;
    localparam logic [3:0] OP_MUL  = 4'hC;
    localparam logic [3:0] OP_CLR  = 4'hD;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_READ = 3'd1,
        ST_EXEC = 3'd2,
        ST_MUL  = 3'd3,
        ST_WB   = 3'd4
    } state_t;

    function automatic logic op_is_illegal(input logic [3:0] op);
`ifdef CPU_EXEC_MUL_EN
        return (op >= 4'hE);
`else
        return (op >= 4'hE) || (op == OP_MUL);
`endif
    endfunction

    function automatic logic op_sets_flags(input logic [3:0] op);
        return ((op >= OP_ADD) && (op <= OP_SHR)) || (op == OP_ADDI) || (op == OP_MUL);
    endfunction

    function automatic logic op_writes(input logic [3:0] op);
        return (op >= OP_ADD) && (op <= OP_MUL);
    endfunction

endpackage

// File: rtl/exec_alu.sv
// Single-cycle combinational ALU for every opcode except the multi-cycle multiply.
module exec_alu
    import cpu_pkg::*;
#(
    parameter int DATA_W = CPU_DATA_W
) (
    input  logic [3:0]        op,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [7:0]        imm,
    output logic [DATA_W-1:0] result,
    output logic              carry
);

    logic [DATA_W-1:0] imm_ext_s;
    logic [DATA_W:0]   sum_s;
    logic [DATA_W:0]   diff_s;
    logic [DATA_W:0]   addi_s;
    logic [DATA_W:0]   shl_s;
    logic [DATA_W:0]   shr_s;
    logic [3:0]        shamt_s;

    assign imm_ext_s = {{(DATA_W-8){1'b0}}, imm};
    assign shamt_s   = b[3:0];
    assign sum_s     = {1'b0, a} + {1'b0, b};
    assign diff_s    = {1'b0, a} - {1'b0, b};
    assign addi_s    = {1'b0, a} + {1'b0, imm_ext_s};
    // Extra guard bit catches the last bit shifted out; a zero shift leaves it 0.
    assign shl_s     = {1'b0, a} << shamt_s;
    assign shr_s     = {a, 1'b0} >> shamt_s;

    // Opcode decode of result and carry.
    always_comb begin
        result = {DATA_W{1'b0}};
        carry  = 1'b0;
        case (op)
            OP_ADD:  begin result = sum_s[DATA_W-1:0];  carry = sum_s[DATA_W];  end
            OP_SUB:  begin result = diff_s[DATA_W-1:0]; carry = diff_s[DATA_W]; end
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_NOT:  result = ~a;
            OP_SHL:  begin result = shl_s[DATA_W-1:0];  carry = shl_s[DATA_W];  end
            OP_SHR:  begin result = shr_s[DATA_W:1];    carry = shr_s[0];       end
            OP_LDI:  result = imm_ext_s;
            OP_ADDI: begin result = addi_s[DATA_W-1:0]; carry = addi_s[DATA_W]; end
            OP_MOV:  result = a;
            default: begin result = {DATA_W{1'b0}};     carry = 1'b0;           end
        endcase
    end

endmodule

// File: rtl/exec_unit.sv
// Execute/write-back controller in front of the register bank: handshake, operand read,
// ALU or shift-add multiply (present only with CPU_EXEC_MUL_EN), write-back and flags.
module exec_unit
    import cpu_pkg::*;
#(
    parameter int DATA_W = CPU_DATA_W,
    parameter int ADDR_W = CPU_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [3:0]        instr_op,
    input  logic [ADDR_W-1:0] instr_rd,
    input  logic [ADDR_W-1:0] instr_ra,
    input  logic [ADDR_W-1:0] instr_rb,
    input  logic [7:0]        instr_imm,
    output logic [ADDR_W-1:0] rf_addr_a,
    output logic [ADDR_W-1:0] rf_addr_b,
    input  logic [DATA_W-1:0] rf_data_a,
    input  logic [DATA_W-1:0] rf_data_b,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_addr_w,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              rf_clear,
    output logic              done,
    output logic              illegal,
    output logic              flag_z,
    output logic              flag_c
);

    state_t            state_r;
    logic [3:0]        op_r;
    logic [ADDR_W-1:0] rd_r;
    logic [7:0]        imm_r;
    logic [DATA_W-1:0] a_r;
    logic [DATA_W-1:0] b_r;
    logic [DATA_W-1:0] alu_result_s;
    logic              alu_carry_s;

`ifdef CPU_EXEC_MUL_EN
    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(DATA_W - 1);
    logic [CNT_W-1:0]  mul_cnt_r;
    logic [DATA_W-1:0] acc_r;
    logic [DATA_W-1:0] mcand_r;
    logic [DATA_W-1:0] mplier_r;
    logic [DATA_W-1:0] acc_nxt_s;

    assign acc_nxt_s = acc_r + (mplier_r[0] ? mcand_r : {DATA_W{1'b0}});
`endif

    exec_alu #(.DATA_W(DATA_W)) u_alu (
        .op     (op_r),
        .a      (a_r),
        .b      (b_r),
        .imm    (imm_r),
        .result (alu_result_s),
        .carry  (alu_carry_s)
    );

    // Controller FSM with all outputs registered; pulse outputs default low each cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r     <= ST_IDLE;
            op_r        <= OP_NOP;
            rd_r        <= {ADDR_W{1'b0}};
            imm_r       <= 8'h00;
            a_r         <= {DATA_W{1'b0}};
            b_r         <= {DATA_W{1'b0}};
            instr_ready <= 1'b1;
            rf_addr_a   <= {ADDR_W{1'b0}};
            rf_addr_b   <= {ADDR_W{1'b0}};
            rf_we       <= 1'b0;
            rf_addr_w   <= {ADDR_W{1'b0}};
            rf_wdata    <= {DATA_W{1'b0}};
            rf_clear    <= 1'b0;
            done        <= 1'b0;
            illegal     <= 1'b0;
            flag_z      <= 1'b0;
            flag_c      <= 1'b0;
`ifdef CPU_EXEC_MUL_EN
            mul_cnt_r   <= {CNT_W{1'b0}};
            acc_r       <= {DATA_W{1'b0}};
            mcand_r     <= {DATA_W{1'b0}};
            mplier_r    <= {DATA_W{1'b0}};
`endif
        end else begin
            rf_we    <= 1'b0;
            rf_clear <= 1'b0;
            done     <= 1'b0;
            illegal  <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (instr_valid) begin
                        op_r        <= instr_op;
                        rd_r        <= instr_rd;
                        imm_r       <= instr_imm;
                        rf_addr_a   <= instr_ra;
                        rf_addr_b   <= instr_rb;
                        instr_ready <= 1'b0;
                        state_r     <= ST_READ;
                    end else begin
                        state_r     <= ST_IDLE;
                    end
                end
                ST_READ: begin
                    a_r <= rf_data_a;
                    b_r <= rf_data_b;
                    // Undefined opcodes retire straight out of EXEC.
                    if (op_is_illegal(op_r)) begin
                        done    <= 1'b1;
                        illegal <= 1'b1;
                        state_r <= ST_EXEC;
`ifdef CPU_EXEC_MUL_EN
                    end else if (op_r == OP_MUL) begin
                        mul_cnt_r <= {CNT_W{1'b0}};
                        acc_r     <= {DATA_W{1'b0}};
                        mcand_r   <= rf_data_a;
                        mplier_r  <= rf_data_b;
                        state_r   <= ST_MUL;
`endif
                    end else begin
                        state_r <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (illegal) begin
                        instr_ready <= 1'b1;
                        state_r     <= ST_IDLE;
                    end else begin
                        rf_addr_w <= rd_r;
                        if (op_writes(op_r)) begin
                            rf_we    <= 1'b1;
                            rf_wdata <= alu_result_s;
                        end else begin
                            rf_we    <= 1'b0;
                        end
                        rf_clear <= (op_r == OP_CLR);
                        if (op_sets_flags(op_r)) begin
                            flag_z <= (alu_result_s == {DATA_W{1'b0}});
                            flag_c <= alu_carry_s;
                        end else begin
                            flag_z <= flag_z;
                        end
                        done    <= 1'b1;
                        state_r <= ST_WB;
                    end
                end
                ST_MUL: begin
`ifdef CPU_EXEC_MUL_EN
                    acc_r     <= acc_nxt_s;
                    mcand_r   <= mcand_r << 1;
                    mplier_r  <= mplier_r >> 1;
                    mul_cnt_r <= mul_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    if (mul_cnt_r == MUL_LAST) begin
                        rf_we     <= 1'b1;
                        rf_addr_w <= rd_r;
                        rf_wdata  <= acc_nxt_s;
                        flag_z    <= (acc_nxt_s == {DATA_W{1'b0}});
                        flag_c    <= 1'b0;
                        done      <= 1'b1;
                        state_r   <= ST_WB;
                    end else begin
                        state_r   <= ST_MUL;
                    end
`else
                    instr_ready <= 1'b1;
                    state_r     <= ST_IDLE;
`endif
                end
                ST_WB: begin
                    instr_ready <= 1'b1;
                    state_r     <= ST_IDLE;
                end
                default: begin
                    instr_ready <= 1'b1;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_exec_unit.sv
// Directed bench for exec_unit with a behavioural 16x16 register bank; MUL expectations
// follow CPU_EXEC_MUL_EN.
module tb_exec_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [3:0]  instr_op = 4'h0;
    logic [3:0]  instr_rd = 4'h0;
    logic [3:0]  instr_ra = 4'h0;
    logic [3:0]  instr_rb = 4'h0;
    logic [7:0]  instr_imm = 8'h00;
    logic [3:0]  rf_addr_a, rf_addr_b, rf_addr_w;
    logic [15:0] rf_data_a, rf_data_b, rf_wdata;
    logic        rf_we, rf_clear, done, illegal, flag_z, flag_c;

    logic [15:0] bank [16];
    int vectors = 0;
    int miscompares = 0;

    exec_unit dut (
        .clk(clk), .reset(reset),
        .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr_op(instr_op), .instr_rd(instr_rd), .instr_ra(instr_ra),
        .instr_rb(instr_rb), .instr_imm(instr_imm),
        .rf_addr_a(rf_addr_a), .rf_addr_b(rf_addr_b),
        .rf_data_a(rf_data_a), .rf_data_b(rf_data_b),
        .rf_we(rf_we), .rf_addr_w(rf_addr_w), .rf_wdata(rf_wdata),
        .rf_clear(rf_clear), .done(done), .illegal(illegal),
        .flag_z(flag_z), .flag_c(flag_c)
    );

    always #5 clk = ~clk;

    assign rf_data_a = bank[rf_addr_a];
    assign rf_data_b = bank[rf_addr_b];

    // Register bank model: write has priority; clear zeroes all entries.
    always @(posedge clk) begin
        if (rf_we) begin
            bank[rf_addr_w] <= rf_wdata;
        end else if (rf_clear) begin
            for (int i = 0; i < 16; i++) bank[i] <= 16'h0000;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_flags(input string tag, input logic z, input logic c);
        chk({tag, ".z"}, {31'd0, flag_z}, {31'd0, z});
        chk({tag, ".c"}, {31'd0, flag_c}, {31'd0, c});
    endtask

    // Offer one instruction, wait for done, check the retirement cycle and the cycle after.
    task automatic run(input string tag, input logic [3:0] op, input logic [3:0] rd,
                       input logic [3:0] ra, input logic [3:0] rb, input logic [7:0] imm,
                       input int exp_k, input logic exp_we, input logic [15:0] exp_data,
                       input logic exp_clr, input logic exp_ill);
        int k;
        int waits = 0;
        @(negedge clk);
        while (!instr_ready && waits < 40) begin
            @(negedge clk);
            waits++;
        end
        chk({tag, ".ready"}, {31'd0, instr_ready}, 32'd1);
        instr_op = op; instr_rd = rd; instr_ra = ra; instr_rb = rb; instr_imm = imm;
        instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        k = 1;
        while (!done && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk({tag, ".done_cycle"}, k, exp_k);
        chk({tag, ".we"}, {31'd0, rf_we}, {31'd0, exp_we});
        if (exp_we) begin
            chk({tag, ".waddr"}, {28'd0, rf_addr_w}, {28'd0, rd});
            chk({tag, ".wdata"}, {16'd0, rf_wdata}, {16'd0, exp_data});
        end
        chk({tag, ".clear"}, {31'd0, rf_clear}, {31'd0, exp_clr});
        chk({tag, ".illegal"}, {31'd0, illegal}, {31'd0, exp_ill});
        @(negedge clk);
        chk({tag, ".post_pulses"}, {29'd0, done, rf_we, rf_clear}, 32'd0);
        chk({tag, ".post_ready"}, {31'd0, instr_ready}, 32'd1);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) bank[i] = 16'h0000;

        // Reset state
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst.ready", {31'd0, instr_ready}, 32'd1);
        chk("rst.pulses", {28'd0, rf_we, rf_clear, done, illegal}, 32'd0);
        chk_flags("rst", 1'b0, 1'b0);
        chk("rst.addrs", {20'd0, rf_addr_a, rf_addr_b, rf_addr_w}, 32'd0);
        chk("rst.wdata", {16'd0, rf_wdata}, 32'd0);
        reset = 1'b1;

        // LDI / ADD
        run("ldi_r1", 4'h9, 4'd1, 4'd0, 4'd0, 8'h05, 3, 1'b1, 16'h0005, 1'b0, 1'b0);
        chk_flags("ldi_r1", 1'b0, 1'b0);
        run("ldi_r2", 4'h9, 4'd2, 4'd0, 4'd0, 8'h03, 3, 1'b1, 16'h0003, 1'b0, 1'b0);
        run("add", 4'h1, 4'd3, 4'd1, 4'd2, 8'h00, 3, 1'b1, 16'h0008, 1'b0, 1'b0);
        chk_flags("add", 1'b0, 1'b0);

        // SUB with borrow
        run("ldi0", 4'h9, 4'd1, 4'd0, 4'd0, 8'h00, 3, 1'b1, 16'h0000, 1'b0, 1'b0);
        run("ldi1", 4'h9, 4'd2, 4'd0, 4'd0, 8'h01, 3, 1'b1, 16'h0001, 1'b0, 1'b0);
        run("sub", 4'h2, 4'd4, 4'd1, 4'd2, 8'h00, 3, 1'b1, 16'hFFFF, 1'b0, 1'b0);
        chk_flags("sub", 1'b0, 1'b1);

        // Build 0x8001, then SHL by 1 and SHR by 0
        run("ldi80", 4'h9, 4'd6, 4'd0, 4'd0, 8'h80, 3, 1'b1, 16'h0080, 1'b0, 1'b0);
        run("ldi8", 4'h9, 4'd7, 4'd0, 4'd0, 8'h08, 3, 1'b1, 16'h0008, 1'b0, 1'b0);
        run("shl8", 4'h7, 4'd6, 4'd6, 4'd7, 8'h00, 3, 1'b1, 16'h8000, 1'b0, 1'b0);
        chk_flags("shl8", 1'b0, 1'b0);
        run("addi", 4'hA, 4'd1, 4'd6, 4'd0, 8'h01, 3, 1'b1, 16'h8001, 1'b0, 1'b0);
        run("shl1", 4'h7, 4'd5, 4'd1, 4'd2, 8'h00, 3, 1'b1, 16'h0002, 1'b0, 1'b0);
        chk_flags("shl1", 1'b0, 1'b1);
        run("ldi_z", 4'h9, 4'd9, 4'd0, 4'd0, 8'h00, 3, 1'b1, 16'h0000, 1'b0, 1'b0);
        run("shr0", 4'h8, 4'd8, 4'd5, 4'd9, 8'h00, 3, 1'b1, 16'h0002, 1'b0, 1'b0);
        chk_flags("shr0", 1'b0, 1'b0);

        // Set carry, then MUL 0x12 * 0x34
        run("add_c", 4'h1, 4'd12, 4'd4, 4'd4, 8'h00, 3, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        chk_flags("add_c", 1'b0, 1'b1);
        run("ldi12", 4'h9, 4'd1, 4'd0, 4'd0, 8'h12, 3, 1'b1, 16'h0012, 1'b0, 1'b0);
        run("ldi34", 4'h9, 4'd2, 4'd0, 4'd0, 8'h34, 3, 1'b1, 16'h0034, 1'b0, 1'b0);
`ifdef CPU_EXEC_MUL_EN
        run("mul", 4'hC, 4'd10, 4'd1, 4'd2, 8'h00, 18, 1'b1, 16'h03A8, 1'b0, 1'b0);
        chk_flags("mul", 1'b0, 1'b0);
`else
        run("mul_ill", 4'hC, 4'd10, 4'd1, 4'd2, 8'h00, 2, 1'b0, 16'h0000, 1'b0, 1'b1);
        chk_flags("mul_ill", 1'b0, 1'b1);
        chk("mul_ill.bank", {16'd0, bank[10]}, 32'd0);
`endif

        // Zero flag, CLR, illegal F, then confirm the bank was cleared
        run("sub_z", 4'h2, 4'd11, 4'd1, 4'd1, 8'h00, 3, 1'b1, 16'h0000, 1'b0, 1'b0);
        chk_flags("sub_z", 1'b1, 1'b0);
        run("clr", 4'hD, 4'd0, 4'd0, 4'd0, 8'h00, 3, 1'b0, 16'h0000, 1'b1, 1'b0);
        chk_flags("clr", 1'b1, 1'b0);
        run("op_f", 4'hF, 4'd3, 4'd1, 4'd2, 8'h00, 2, 1'b0, 16'h0000, 1'b0, 1'b1);
        chk_flags("op_f", 1'b1, 1'b0);
        run("addi_clr", 4'hA, 4'd1, 4'd1, 4'd0, 8'h07, 3, 1'b1, 16'h0007, 1'b0, 1'b0);
        chk_flags("addi_clr", 1'b0, 1'b0);
        run("sub_c", 4'h2, 4'd14, 4'd0, 4'd1, 8'h00, 3, 1'b1, 16'hFFF9, 1'b0, 1'b0);
        chk_flags("sub_c", 1'b0, 1'b1);

        // Reset during the EXEC cycle of an ADD
        @(negedge clk);
        instr_op = 4'h1; instr_rd = 4'd3; instr_ra = 4'd1; instr_rb = 4'd1;
        instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("mid_rst.pulses", {29'd0, rf_we, rf_clear, done}, 32'd0);
        chk_flags("mid_rst", 1'b0, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst.ready", {31'd0, instr_ready}, 32'd1);
        chk("mid_rst.pulses2", {29'd0, rf_we, rf_clear, done}, 32'd0);
        @(negedge clk);
        chk("mid_rst.bank3", {16'd0, bank[3]}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
